// File: rtl/smart_cargo_scan_ctrl.sv
// SCAN-scheduling lift movement controller for N floors: pending-stop bitmap,
// direction-preserving stop selection, emergency hold and a latched travel/sensor fault.
module smart_cargo_scan_ctrl #(
  parameter int N_FLOORS     = 4,
  parameter int FLOOR_W      = 2,
  parameter int DWELL_CYCLES = 100000000,
  parameter int TRAVEL_MAX   = 250000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  input  logic [N_FLOORS-1:0] sensores,
  input  logic                emergencia,
  output logic                motorSubindo,
  output logic                motorDescendo,
  output logic                porta_aberta,
  output logic [FLOOR_W-1:0]  andarAtual,
  output logic [FLOOR_W-1:0]  proxParada,
  output logic [N_FLOORS-1:0] pendentes,
  output logic                falha,
  output logic [2:0]          db_estado
);

  typedef enum logic [2:0] {
    INIT = 3'd0, IDLE = 3'd1, SUBINDO = 3'd2, DESCENDO = 3'd3,
    PARADO = 3'd4, EMERG = 3'd5, FALHA = 3'd6
  } state_t;

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int TW = $clog2(TRAVEL_MAX + 1);

  state_t              state, state_n;
  logic [N_FLOORS-1:0] s1, s2, s3;
  logic [DW-1:0]       dwell, dwell_n;
  logic [TW-1:0]       travel, travel_n;
  logic                dir_up, dir_n;
  logic [FLOOR_W-1:0]  cur_n, prox_n;
  logic [N_FLOORS-1:0] set_mask, clr_mask, pend_set;
  logic [N_FLOORS-1:0] edge_v, cur_oh, req_oh, above, below;
  logic [FLOOR_W-1:0]  up_tgt, dn_tgt, idle_tgt, edge_f, sens_f;
  logic                any_s, multi, has_above, has_below, pend_at_cur, go_up;
  logic                req_ok, motor_on, wd_trip;

  // Lowest set bit index; callers only rely on it when the vector is one-hot.
  function automatic logic [FLOOR_W-1:0] enc(input logic [N_FLOORS-1:0] v);
    enc = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (v[i]) enc = FLOOR_W'(i);
  endfunction

  assign edge_v      = s2 & ~s3;
  assign any_s       = |s2;
  assign multi       = |(s2 & (s2 - N_FLOORS'(1)));
  assign edge_f      = enc(edge_v);
  assign sens_f      = enc(s2);
  assign cur_oh      = N_FLOORS'(1) << andarAtual;
  assign req_ok      = int'(req_floor) < N_FLOORS;
  assign req_oh      = req_ok ? (N_FLOORS'(1) << req_floor) : '0;
  assign pend_at_cur = |(pendentes & cur_oh);
  assign motor_on    = motorSubindo | motorDescendo;
  assign wd_trip     = motor_on && !(|edge_v) && (travel == TW'(TRAVEL_MAX - 1));

  always_comb begin
    above  = '0;
    below  = '0;
    up_tgt = andarAtual;
    dn_tgt = andarAtual;
    for (int i = 0; i < N_FLOORS; i++) begin
      above[i] = pendentes[i] && (i > int'(andarAtual));
      below[i] = pendentes[i] && (i < int'(andarAtual));
    end
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (above[i]) up_tgt = FLOOR_W'(i);
    for (int i = 0; i < N_FLOORS; i++)
      if (below[i]) dn_tgt = FLOOR_W'(i);
  end

  assign has_above = |above;
  assign has_below = |below;
  // Keep heading the same way while it still has work, otherwise reverse.
  assign go_up     = dir_up ? has_above : !has_below;
  assign idle_tgt  = go_up ? up_tgt : dn_tgt;

  always_comb begin
    prox_n = andarAtual;
    if (pendentes != '0) begin
      case (state)
        SUBINDO:  prox_n = has_above ? up_tgt : andarAtual;
        DESCENDO: prox_n = has_below ? dn_tgt : andarAtual;
        default:  prox_n = pend_at_cur ? andarAtual : idle_tgt;
      endcase
    end
  end

  always_comb begin
    set_mask = '0;
    if (req_valid && state != FALHA && !(state == PARADO && req_floor == andarAtual))
      set_mask = req_oh;
    pend_set = pendentes | set_mask;
    state_n  = state;
    cur_n    = andarAtual;
    clr_mask = '0;
    dir_n    = dir_up;
    dwell_n  = '0;
    travel_n = (motor_on && !(|edge_v)) ? travel + TW'(1) : '0;
    case (state)
      INIT:
        if (any_s && !multi) begin
          cur_n   = sens_f;
          state_n = IDLE;
        end
      IDLE:
        if (pendentes != '0) begin
          if (pend_at_cur) begin
            clr_mask = cur_oh;
            state_n  = PARADO;
          end else begin
            dir_n   = go_up;
            state_n = go_up ? SUBINDO : DESCENDO;
          end
        end
      SUBINDO, DESCENDO:
        if (|edge_v) begin
          cur_n = edge_f;
          // A request landing on the arrival edge is served by this stop.
          if (|(pend_set & edge_v)) begin
            clr_mask = edge_v;
            state_n  = PARADO;
          end
        end
      PARADO:
        if (dwell == DW'(DWELL_CYCLES - 1)) state_n = IDLE;
        else dwell_n = dwell + DW'(1);
      EMERG:
        if (!emergencia) state_n = any_s ? IDLE : INIT;
      default: ;
    endcase
    if (emergencia && state inside {INIT, IDLE, SUBINDO, DESCENDO, PARADO}) begin
      state_n  = EMERG;
      clr_mask = '0;
      dwell_n  = '0;
    end
    if (state != FALHA && (multi || wd_trip)) begin
      state_n  = FALHA;
      clr_mask = '0;
      dwell_n  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= INIT;
      s1            <= '0;
      s2            <= '0;
      s3            <= '0;
      andarAtual    <= '0;
      proxParada    <= '0;
      pendentes     <= '0;
      dwell         <= '0;
      travel        <= '0;
      dir_up        <= 1'b1;
      motorSubindo  <= 1'b0;
      motorDescendo <= 1'b0;
      porta_aberta  <= 1'b0;
    end else begin
      state         <= state_n;
      s1            <= sensores;
      s2            <= s1;
      s3            <= s2;
      andarAtual    <= cur_n;
      proxParada    <= prox_n;
      pendentes     <= pend_set & ~clr_mask;
      dwell         <= dwell_n;
      travel        <= travel_n;
      dir_up        <= dir_n;
      motorSubindo  <= (state_n == SUBINDO);
      motorDescendo <= (state_n == DESCENDO) || (state_n == INIT && !any_s);
      porta_aberta  <= (state_n == PARADO);
    end
  end

  assign falha     = (state == FALHA);
  assign db_estado = state;

endmodule

// File: tb/tb_smart_cargo_scan_ctrl.sv
// Directed bench: a tiny lift plant moves sensores from the motor outputs; expected
// stop floors go into a scoreboard queue and are checked at each door opening.
module tb_smart_cargo_scan_ctrl;
  localparam int N  = 4;
  localparam int FW = 3;
  localparam int DW = 5;
  localparam int TM = 30;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic [N-1:0]  sensores = '0;
  logic          emergencia = 1'b0;
  logic          motorSubindo, motorDescendo, porta_aberta, falha;
  logic [FW-1:0] andarAtual, proxParada;
  logic [N-1:0]  pendentes;
  logic [2:0]    db_estado;

  int checks = 0;
  int failures = 0;
  int pos = 0;
  int seg = 0;
  bit plant_en = 1'b0;
  logic [N-1:0] one = 1;
  int sb[$];

  smart_cargo_scan_ctrl #(.N_FLOORS(N), .FLOOR_W(FW), .DWELL_CYCLES(DW), .TRAVEL_MAX(TM)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .sensores(sensores), .emergencia(emergencia), .motorSubindo(motorSubindo),
    .motorDescendo(motorDescendo), .porta_aberta(porta_aberta), .andarAtual(andarAtual),
    .proxParada(proxParada), .pendentes(pendentes), .falha(falha), .db_estado(db_estado));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are then stable at the falling edge, where the plant reacts.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    if (plant_en && (motorSubindo || motorDescendo)) begin
      seg++;
      if (seg == 4) sensores = '0;
      if (seg == 8) begin
        pos += motorSubindo ? 1 : -1;
        sensores = one << pos;
        seg = 0;
      end
    end else seg = 0;
  endtask

  task automatic req(input int f);
    req_valid = 1'b1;
    req_floor = FW'(f);
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_to_stop(input string tag);
    int n;
    int exp;
    bit moved;
    n = 0;
    while (!porta_aberta && n < 300) begin step(); n++; end
    chk({tag, "_door_timeout"}, 32'(porta_aberta), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : -1;
    chk({tag, "_floor"}, 32'(andarAtual), 32'(exp));
    n = 0;
    moved = 1'b0;
    while (porta_aberta && n < 100) begin
      if (motorSubindo || motorDescendo) moved = 1'b1;
      n++;
      step();
    end
    chk({tag, "_dwell"}, 32'(n), 32'(DW));
    chk({tag, "_motor_in_dwell"}, 32'(moved), 32'd0);
    chk({tag, "_idle_after"}, 32'(db_estado), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (db_estado != 3'd1 && n < 10) begin step(); n++; end
    chk({tag, "_idle_timeout"}, 32'(db_estado), 32'd1);
  endtask

  initial begin
    int n;
    // Reset state, lift parked at floor 2
    sensores = 4'b0100;
    pos = 2;
    step();
    chk("rst_state", 32'(db_estado), 32'd0);
    chk("rst_motors", 32'({motorSubindo, motorDescendo, porta_aberta}), 32'd0);
    chk("rst_pend", 32'(pendentes), 32'd0);
    chk("rst_falha", 32'(falha), 32'd0);
    chk("rst_prox", 32'(proxParada), 32'd0);
    reset = 1'b1;
    wait_idle("init");
    chk("init_floor", 32'(andarAtual), 32'd2);
    chk("init_pend", 32'(pendentes), 32'd0);
    step();
    chk("init_motors", 32'({motorSubindo, motorDescendo}), 32'd0);
    plant_en = 1'b1;

    // Down to 0
    req(0); sb.push_back(0);
    run_to_stop("a0");

    // From 0: requests 3 then 1, stops at 1 first
    req(3);
    chk("a_pend_3", 32'(pendentes), 32'h8);
    req(1); sb.push_back(1); sb.push_back(3);
    chk("a_prox_3", 32'(proxParada), 32'd3);
    chk("a_up", 32'(motorSubindo), 32'd1);
    step();
    chk("a_prox_1", 32'(proxParada), 32'd1);
    run_to_stop("a1");
    chk("a_pend_after1", 32'(pendentes), 32'h8);
    run_to_stop("a3");
    chk("a_pend_empty", 32'(pendentes), 32'd0);

    // Down to 1, then up with {3,0} pending: 3 served before reversing
    req(1); sb.push_back(1);
    run_to_stop("b1");
    req(3); sb.push_back(3);
    step(); step();
    req(0); sb.push_back(0);
    chk("b_pend_30", 32'(pendentes), 32'h9);
    run_to_stop("b3");
    step();
    chk("b_reverse", 32'(motorDescendo), 32'd1);
    run_to_stop("b0");

    // Emergency right after departure, then resume to the same stop
    req(2); sb.push_back(2);
    n = 0;
    while (!motorSubindo && n < 10) begin step(); n++; end
    chk("c_moving", 32'(motorSubindo), 32'd1);
    emergencia = 1'b1;
    step();
    chk("c_motors_off", 32'({motorSubindo, motorDescendo}), 32'd0);
    chk("c_state", 32'(db_estado), 32'd5);
    chk("c_pend_kept", 32'(pendentes), 32'h4);
    step(); step();
    emergencia = 1'b0;
    run_to_stop("c2");

    // Out-of-range request
    req(5);
    step();
    chk("oor_pend", 32'(pendentes), 32'd0);
    chk("oor_state", 32'(db_estado), 32'd1);

    // Watchdog: motor on, no floor edge
    plant_en = 1'b0;
    req(3);
    n = 0;
    while (!falha && n < 100) begin step(); n++; end
    chk("wd_falha", 32'(falha), 32'd1);
    chk("wd_state", 32'(db_estado), 32'd6);
    chk("wd_motors", 32'({motorSubindo, motorDescendo, porta_aberta}), 32'd0);
    chk("wd_pend", 32'(pendentes), 32'h8);
    req(1);
    step();
    chk("wd_req_ignored", 32'(pendentes), 32'h8);

    // Multi-sensor fault while moving
    reset = 1'b0;
    sensores = 4'b0001;
    pos = 0;
    step(); step();
    reset = 1'b1;
    wait_idle("e_init");
    chk("e_floor", 32'(andarAtual), 32'd0);
    plant_en = 1'b1;
    req(2);
    n = 0;
    while (!motorSubindo && n < 10) begin step(); n++; end
    plant_en = 1'b0;
    sensores = 4'b0110;
    n = 0;
    while (!falha && n < 10) begin step(); n++; end
    chk("e_falha", 32'(falha), 32'd1);
    chk("e_motors", 32'({motorSubindo, motorDescendo}), 32'd0);
    req(0);
    step();
    chk("e_req_ignored", 32'(pendentes), 32'h4);
    reset = 1'b0;
    step();
    chk("e_rst_falha", 32'(falha), 32'd0);
    chk("e_rst_pend", 32'(pendentes), 32'd0);
    chk("e_rst_state", 32'(db_estado), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
